// File: rtl/window_fifo.sv
// Circular-buffer FIFO of convolution window words; rd_data/rd_valid one cycle after an accepted read.
// A full FIFO drops writes (overflow pulse) unless a read frees the slot the same cycle.
module window_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 3,
    parameter int F          = 3,
    parameter int DEPTH      = 256,
    parameter int AFULL_TH   = DEPTH - 4,
    parameter int AEMPTY_TH  = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic                               wr_en,
    input  logic [D*F*F*DATA_WIDTH-1:0]        wr_data,
    input  logic                               rd_en,
    output logic [D*F*F*DATA_WIDTH-1:0]        rd_data,
    output logic                               rd_valid,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int W  = D * F * F * DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          full_s, empty_s;
    logic          wr_ok, rd_ok;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == '0);

    always_comb begin
        wr_ok       = 1'b0;
        rd_ok       = 1'b0;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            rd_ok       = rd_en & ~empty_s;
            wr_ok       = wr_en & (~full_s | rd_ok);
            overflow_d  = wr_en & ~wr_ok;
            underflow_d = rd_en & empty_s;
            if (rd_ok) begin
                rd_data_d  = mem[rptr_q];
                rd_valid_d = 1'b1;
                rptr_d     = ptr_inc(rptr_q);
            end
            if (wr_ok) begin
                wptr_d = ptr_inc(wptr_q);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign count        = count_q;
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= CW'(AFULL_TH));
    assign almost_empty = (count_q <= CW'(AEMPTY_TH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_window_fifo.sv
module tb_window_fifo;

    localparam int DW    = 16;
    localparam int D     = 3;
    localparam int F     = 3;
    localparam int W     = D * F * F * DW;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush = 1'b0;
    logic         wr_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en = 1'b0;
    logic [W-1:0] rd_data;
    logic         rd_valid, full, empty, almost_full, almost_empty;
    logic [3:0]   count;
    logic         overflow, underflow;

    int tests = 0;
    int fails = 0;

    window_fifo #(
        .DATA_WIDTH(DW), .D(D), .F(F), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of accepted words plus the last read result.
    logic [W-1:0] q[$];
    logic [W-1:0] m_data = '0;
    logic         m_vld = 1'b0, m_ov = 1'b0, m_un = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_data = '0; m_vld = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else if (flush) begin
            q.delete();
            m_vld = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            automatic int  n   = q.size();
            automatic bit  rok = rd_en && n > 0;
            automatic bit  wok = wr_en && (n < DEPTH || rok);
            m_vld = rok;
            if (rok) m_data = q.pop_front();
            if (wok) q.push_back(wr_data);
            m_ov = wr_en && !wok;
            m_un = rd_en && n == 0;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        automatic int n = q.size();
        chk("count",        W'(count),        W'(n));
        chk("full",         W'(full),         W'(n == DEPTH));
        chk("empty",        W'(empty),        W'(n == 0));
        chk("almost_full",  W'(almost_full),  W'(n >= AF));
        chk("almost_empty", W'(almost_empty), W'(n <= AE));
        chk("rd_valid",     W'(rd_valid),     W'(m_vld));
        chk("rd_data",      rd_data,          m_data);
        chk("overflow",     W'(overflow),     W'(m_ov));
        chk("underflow",    W'(underflow),    W'(m_un));
    end

    task automatic step(input logic f, input logic w, input logic [W-1:0] d, input logic r);
        flush = f; wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32 + 1; i++) v = {v[W-33:0], 32'($urandom)};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        chk("rst_empty", W'(empty), W'(1));
        chk("rst_count", W'(count), W'(0));
        chk("rst_ae",    W'(almost_empty), W'(1));
        chk("rst_af",    W'(almost_full),  W'(0));

        // Five writes then five reads.
        for (int i = 1; i <= 5; i++) step(0, 1, W'(i), 0);
        chk("count5", W'(count), W'(5));
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, '0, 1);
            chk("seq_data", rd_data, W'(i));
            chk("seq_vld",  W'(rd_valid), W'(1));
        end
        chk("seq_empty", W'(empty), W'(1));

        // Fill, overflow, then sustained read+write while full.
        for (int i = 0; i < DEPTH; i++) step(0, 1, W'(8'h10 + i), 0);
        chk("fill_full", W'(full), W'(1));
        step(0, 1, W'(8'hAA), 0);
        chk("ovf_pulse", W'(overflow), W'(1));
        chk("ovf_count", W'(count), W'(8));
        step(0, 0, '0, 0);
        chk("ovf_clear", W'(overflow), W'(0));
        for (int k = 0; k < 20; k++) begin
            step(0, 1, W'(12'h100 + k), 1);
            chk("wrap_full", W'(full), W'(1));
            if (k < DEPTH) chk("wrap_orig", rd_data, W'(8'h10 + k));
            else           chk("wrap_new",  rd_data, W'(12'h100 + k - DEPTH));
        end
        for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1);

        // Read while empty with a concurrent write.
        step(0, 1, W'(7), 1);
        chk("und_pulse", W'(underflow), W'(1));
        chk("und_vld",   W'(rd_valid),  W'(0));
        chk("und_count", W'(count),     W'(1));
        step(0, 0, '0, 1);
        chk("und_data",  rd_data, W'(7));

        // Threshold walk, one write at a time.
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 1, W'(i), 0);
            chk("th_ae", W'(almost_empty), W'(i <= 2));
            chk("th_af", W'(almost_full),  W'(i >= 6));
        end

        // Flush at count 5 with both requests high.
        step(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, W'(8'h50 + i), 0);
        step(1, 1, W'(8'h99), 1);
        chk("fl_count", W'(count), W'(0));
        chk("fl_empty", W'(empty), W'(1));
        chk("fl_ovf",   W'(overflow),  W'(0));
        chk("fl_und",   W'(underflow), W'(0));
        chk("fl_vld",   W'(rd_valid),  W'(0));

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) step(0, 1, W'(8'h60 + i), 0);
        step(0, 0, '0, 1);
        wr_en = 1'b0; rd_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("ar_count", W'(count),    W'(0));
        chk("ar_empty", W'(empty),    W'(1));
        chk("ar_data",  rd_data,      '0);
        chk("ar_vld",   W'(rd_valid), W'(0));
        @(negedge clk) reset = 1'b0;

        // Randomized traffic with varying read/write bias.
        for (int ph = 0; ph < 6; ph++) begin
            automatic int wp = $urandom_range(20, 90);
            automatic int rp = $urandom_range(20, 90);
            for (int c = 0; c < 150; c++) begin
                step($urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < wp, rnd_word(),
                     $urandom_range(0, 99) < rp);
            end
        end
        step(0, 0, '0, 0);
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
